// File: rtl/q_edge_monitor.sv
// Purpose : debounce the flip-flop stage's q, emit rise/fall pulses, count transitions, host snapshot.
// Latency : stable_q and pulses at sample edge + DEBOUNCE_CYCLES; edge_count one edge later.
// Backpr. : none on q_in; snapshot is req/ack, HOLD state freezes snap_count until ack.
//
// Ports:
//   clock0, rstn (sync, active low)        clock and reset
//   q_in                                   same-clock q from the flip-flop stage
//   clear                                  zeroes edge_count and count_sat
//   stable_q, rise_pulse, fall_pulse       debounced level and one-cycle change pulses
//   edge_count, count_sat                  saturating transition counter and sticky saturation flag
//   snap_req, snap_ack                     host snapshot handshake
//   snap_valid, snap_count                 held snapshot of edge_count
module q_edge_monitor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clock0,
  input  logic                 rstn,
  input  logic                 q_in,
  input  logic                 clear,
  output logic                 stable_q,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 count_sat,
  input  logic                 snap_req,
  input  logic                 snap_ack,
  output logic                 snap_valid,
  output logic [CNT_WIDTH-1:0] snap_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_e;

  localparam logic [7:0]           RUN_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_PENULT = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  logic                 q_r_q, q_r_d;
  logic [7:0]           run_cnt_q, run_cnt_d;
  logic                 stable_lvl_q, stable_lvl_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] edge_count_q, edge_count_d;
  logic                 count_sat_q, count_sat_d;
  logic                 snap_valid_q, snap_valid_d;
  logic [CNT_WIDTH-1:0] snap_count_q, snap_count_d;
  snap_state_e          state_q, state_d;

  // Debouncer: run_cnt counts consecutive edges on which the sampled level
  // disagrees with the accepted level; a single agreeing sample restarts it.
  always_comb begin
    q_r_d        = q_in;
    run_cnt_d    = run_cnt_q;
    stable_lvl_d = stable_lvl_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    if (q_r_q == stable_lvl_q) begin
      run_cnt_d = 8'd0;
    end else if (run_cnt_q == RUN_LAST) begin
      stable_lvl_d = q_r_q;
      run_cnt_d    = 8'd0;
      rise_d       = q_r_q;
      fall_d       = ~q_r_q;
    end else begin
      run_cnt_d = run_cnt_q + 8'd1;
    end
  end

  // Counter counts the registered pulses, so it lags stable_q by one edge.
  // Clear takes priority over a coincident pulse.
  always_comb begin
    edge_count_d = edge_count_q;
    count_sat_d  = count_sat_q;
    if (clear) begin
      edge_count_d = '0;
      count_sat_d  = 1'b0;
    end else if ((rise_q || fall_q) && (edge_count_q != CNT_MAX)) begin
      edge_count_d = edge_count_q + CNT_ONE;
      if (edge_count_q == CNT_PENULT) begin
        count_sat_d = 1'b1;
      end
    end
  end

  // Snapshot FSM: capture the pre-edge count in IDLE, hold it until ack.
  always_comb begin
    state_d      = state_q;
    snap_valid_d = snap_valid_q;
    snap_count_d = snap_count_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          snap_count_d = edge_count_q;
          snap_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (snap_ack) begin
          snap_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        snap_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock0) begin
    if (!rstn) begin
      q_r_q        <= 1'b0;
      run_cnt_q    <= 8'd0;
      stable_lvl_q <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      edge_count_q <= '0;
      count_sat_q  <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_count_q <= '0;
      state_q      <= IDLE;
    end else begin
      q_r_q        <= q_r_d;
      run_cnt_q    <= run_cnt_d;
      stable_lvl_q <= stable_lvl_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      edge_count_q <= edge_count_d;
      count_sat_q  <= count_sat_d;
      snap_valid_q <= snap_valid_d;
      snap_count_q <= snap_count_d;
      state_q      <= state_d;
    end
  end

  assign stable_q   = stable_lvl_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign edge_count = edge_count_q;
  assign count_sat  = count_sat_q;
  assign snap_valid = snap_valid_q;
  assign snap_count = snap_count_q;

endmodule

// File: tb/tb_q_edge_monitor.sv
module tb_q_edge_monitor;

  localparam int D    = 4;
  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         q_in = 1'b0;
  logic         clear = 1'b0;
  logic         snap_req = 1'b0;
  logic         snap_ack = 1'b0;
  logic         stable_q, rise_pulse, fall_pulse, count_sat, snap_valid;
  logic [W-1:0] edge_count, snap_count;

  int checks = 0;
  int errors = 0;

  q_edge_monitor #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(W)) u_dut (
    .clock0(clk), .rstn(rstn), .q_in(q_in), .clear(clear),
    .stable_q(stable_q), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .edge_count(edge_count), .count_sat(count_sat),
    .snap_req(snap_req), .snap_ack(snap_ack),
    .snap_valid(snap_valid), .snap_count(snap_count)
  );

  always #5 clk = ~clk;

  // Reference model: a sliding window of the last D registered samples. The
  // level flips when every sample in the window disagrees with it.
  bit m_qr = 0, m_stable = 0, m_rise = 0, m_fall = 0, m_sat = 0, m_sv = 0;
  int m_cnt = 0, m_sc = 0;
  bit hist[$];
  int old_cnt;
  bit had_pulse, all_diff;

  always @(posedge clk) begin
    if (!rstn) begin
      m_qr = 0; m_stable = 0; m_rise = 0; m_fall = 0;
      m_cnt = 0; m_sat = 0; m_sv = 0; m_sc = 0;
      hist.delete();
      for (int i = 0; i < D; i++) hist.push_back(1'b0);
    end else begin
      old_cnt   = m_cnt;
      had_pulse = m_rise | m_fall;
      hist.push_back(m_qr);
      void'(hist.pop_front());
      all_diff = 1;
      foreach (hist[i]) if (hist[i] == m_stable) all_diff = 0;
      m_rise = 0; m_fall = 0;
      if (all_diff) begin
        m_stable = !m_stable;
        m_rise = m_stable;
        m_fall = !m_stable;
      end
      if (clear) begin
        m_cnt = 0; m_sat = 0;
      end else if (had_pulse && m_cnt < MAXC) begin
        m_cnt++;
        if (m_cnt == MAXC) m_sat = 1;
      end
      if (!m_sv) begin
        if (snap_req) begin m_sc = old_cnt; m_sv = 1; end
      end else if (snap_ack) begin
        m_sv = 0;
      end
      m_qr = q_in;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle(input bit v);
    q_in = v;
    repeat (D + 2) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0; tick(); rstn = 1'b1;
  endtask

  task automatic wait_pulse();
    int n = 0;
    while (!(rise_pulse || fall_pulse) && n < 20) begin tick(); n++; end
    checks++;
    if (!(rise_pulse || fall_pulse)) begin
      errors++; $display("FAIL wait_pulse: pulse=0 after 20 cycles, required 1");
    end
  endtask

  task automatic test_reset();
    q_in = 1'b1; clear = 1'b0; snap_req = 1'b1; snap_ack = 1'b0;
    rstn = 1'b0; tick(); tick();
    checks += 8;
    if (stable_q !== 1'b0)   begin errors++; $display("FAIL reset_stable: got %b want 0", stable_q); end
    if (rise_pulse !== 1'b0) begin errors++; $display("FAIL reset_rise: got %b want 0", rise_pulse); end
    if (fall_pulse !== 1'b0) begin errors++; $display("FAIL reset_fall: got %b want 0", fall_pulse); end
    if (edge_count !== '0)   begin errors++; $display("FAIL reset_cnt: got %0d want 0", edge_count); end
    if (count_sat !== 1'b0)  begin errors++; $display("FAIL reset_sat: got %b want 0", count_sat); end
    if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_sv: got %b want 0", snap_valid); end
    if (snap_count !== '0)   begin errors++; $display("FAIL reset_sc: got %0d want 0", snap_count); end
    if (stable_q !== m_stable) begin errors++; $display("FAIL reset_model: got %b want %b", stable_q, m_stable); end
    q_in = 1'b0; snap_req = 1'b0; rstn = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_debounce();
    bit es, er;
    int ec;
    q_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      es = (i >= D + 1);
      er = (i == D + 1);
      ec = (i >= D + 2) ? 1 : 0;
      checks += 4;
      if (stable_q !== es)   begin errors++; $display("FAIL deb_stable[%0d]: got %b want %b", i, stable_q, es); end
      if (rise_pulse !== er) begin errors++; $display("FAIL deb_rise[%0d]: got %b want %b", i, rise_pulse, er); end
      if (fall_pulse !== 1'b0) begin errors++; $display("FAIL deb_fall[%0d]: got %b want 0", i, fall_pulse); end
      if (edge_count !== W'(ec)) begin errors++; $display("FAIL deb_cnt[%0d]: got %0d want %0d", i, edge_count, ec); end
    end
  endtask

  task automatic test_glitch();
    settle(1'b0);
    checks++;
    if (edge_count !== W'(2)) begin errors++; $display("FAIL glitch_pre_cnt: got %0d want 2", edge_count); end
    q_in = 1'b1; repeat (3) tick(); q_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks += 3;
      if (stable_q !== 1'b0)   begin errors++; $display("FAIL glitch_stable[%0d]: got %b want 0", i, stable_q); end
      if (rise_pulse !== 1'b0) begin errors++; $display("FAIL glitch_rise[%0d]: got %b want 0", i, rise_pulse); end
      if (edge_count !== W'(2)) begin errors++; $display("FAIL glitch_cnt[%0d]: got %0d want 2", i, edge_count); end
    end
    for (int i = 0; i < 16; i++) begin
      q_in = ~q_in; tick();
      checks++;
      if (rise_pulse || fall_pulse) begin errors++; $display("FAIL toggle_pulse[%0d]: got %b%b want 00", i, rise_pulse, fall_pulse); end
    end
    settle(1'b0);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      settle(i[0]);
      if (i == 14) begin
        checks += 2;
        if (edge_count !== W'(14)) begin errors++; $display("FAIL sat_cnt14: got %0d want 14", edge_count); end
        if (count_sat !== 1'b0)    begin errors++; $display("FAIL sat_flag14: got %b want 0", count_sat); end
      end
    end
    checks += 2;
    if (edge_count !== W'(MAXC)) begin errors++; $display("FAIL sat_cnt: got %0d want %0d", edge_count, MAXC); end
    if (count_sat !== 1'b1)      begin errors++; $display("FAIL sat_flag: got %b want 1", count_sat); end
    clear = 1'b1; tick(); clear = 1'b0;
    checks += 2;
    if (edge_count !== '0)  begin errors++; $display("FAIL clear_cnt: got %0d want 0", edge_count); end
    if (count_sat !== 1'b0) begin errors++; $display("FAIL clear_flag: got %b want 0", count_sat); end
    q_in = 1'b1; wait_pulse();
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (2) tick();
    checks += 2;
    if (edge_count !== '0) begin errors++; $display("FAIL clear_pulse_cnt: got %0d want 0", edge_count); end
    if (stable_q !== 1'b1) begin errors++; $display("FAIL clear_pulse_stable: got %b want 1", stable_q); end
  endtask

  task automatic test_snapshot();
    do_reset();
    for (int i = 1; i <= 7; i++) settle(i[0]);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    checks += 2;
    if (snap_valid !== 1'b1)  begin errors++; $display("FAIL snap_valid: got %b want 1", snap_valid); end
    if (snap_count !== W'(7)) begin errors++; $display("FAIL snap_count: got %0d want 7", snap_count); end
    snap_req = 1'b1;
    settle(1'b0); settle(1'b1);
    snap_req = 1'b0;
    checks += 3;
    if (snap_count !== W'(7)) begin errors++; $display("FAIL snap_frozen: got %0d want 7", snap_count); end
    if (snap_valid !== 1'b1)  begin errors++; $display("FAIL snap_held: got %b want 1", snap_valid); end
    if (edge_count !== W'(9)) begin errors++; $display("FAIL snap_live_cnt: got %0d want 9", edge_count); end
    snap_ack = 1'b1; tick(); snap_ack = 1'b0;
    checks++;
    if (snap_valid !== 1'b0) begin errors++; $display("FAIL snap_release: got %b want 0", snap_valid); end
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    checks += 2;
    if (snap_valid !== 1'b1)  begin errors++; $display("FAIL snap2_valid: got %b want 1", snap_valid); end
    if (snap_count !== W'(9)) begin errors++; $display("FAIL snap2_count: got %0d want 9", snap_count); end
    snap_ack = 1'b1; tick(); snap_ack = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    settle(1'b1); settle(1'b0); settle(1'b1);
    q_in = 1'b0; wait_pulse();
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    checks += 2;
    if (snap_count !== W'(3)) begin errors++; $display("FAIL simul_snap: got %0d want 3", snap_count); end
    if (edge_count !== W'(4)) begin errors++; $display("FAIL simul_cnt: got %0d want 4", edge_count); end
    snap_ack = 1'b1; tick();
    tick(); snap_ack = 1'b0;
    checks += 2;
    if (snap_valid !== 1'b0)  begin errors++; $display("FAIL idle_ack_valid: got %b want 0", snap_valid); end
    if (snap_count !== W'(3)) begin errors++; $display("FAIL idle_ack_count: got %0d want 3", snap_count); end
    snap_req = 1'b1; snap_ack = 1'b1; tick();
    checks += 2;
    if (snap_valid !== 1'b1)  begin errors++; $display("FAIL both_idle_valid: got %b want 1", snap_valid); end
    if (snap_count !== W'(4)) begin errors++; $display("FAIL both_idle_count: got %0d want 4", snap_count); end
    tick(); snap_req = 1'b0; snap_ack = 1'b0;
    checks++;
    if (snap_valid !== 1'b0) begin errors++; $display("FAIL both_hold_valid: got %b want 0", snap_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    settle(1'b1);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    q_in = 1'b0; repeat (3) tick();
    rstn = 1'b0; tick(); rstn = 1'b1;
    checks += 3;
    if (snap_valid !== 1'b0) begin errors++; $display("FAIL rmid_sv: got %b want 0", snap_valid); end
    if (edge_count !== '0)   begin errors++; $display("FAIL rmid_cnt: got %0d want 0", edge_count); end
    if (stable_q !== 1'b0)   begin errors++; $display("FAIL rmid_stable: got %b want 0", stable_q); end
    repeat (D + 2) tick();
    checks++;
    if (stable_q !== 1'b0) begin errors++; $display("FAIL rmid_hold0: got %b want 0", stable_q); end
    settle(1'b1);
    checks += 2;
    if (stable_q !== 1'b1)    begin errors++; $display("FAIL rmid_resume_stable: got %b want 1", stable_q); end
    if (edge_count !== W'(1)) begin errors++; $display("FAIL rmid_resume_cnt: got %0d want 1", edge_count); end
  endtask

  task automatic test_random();
    int hold_left = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        q_in = $urandom_range(0, 1);
        hold_left = $urandom_range(1, 2 * D);
      end
      hold_left--;
      clear    = ($urandom_range(0, 59) == 0);
      snap_req = ($urandom_range(0, 5) == 0);
      snap_ack = ($urandom_range(0, 5) == 0);
      rstn     = ($urandom_range(0, 399) != 0);
      tick();
      checks += 7;
      if (stable_q !== m_stable)  begin errors++; $display("FAIL rnd_stable[%0d]: got %b want %b", i, stable_q, m_stable); end
      if (rise_pulse !== m_rise)  begin errors++; $display("FAIL rnd_rise[%0d]: got %b want %b", i, rise_pulse, m_rise); end
      if (fall_pulse !== m_fall)  begin errors++; $display("FAIL rnd_fall[%0d]: got %b want %b", i, fall_pulse, m_fall); end
      if (edge_count !== W'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, edge_count, m_cnt); end
      if (count_sat !== m_sat)    begin errors++; $display("FAIL rnd_sat[%0d]: got %b want %b", i, count_sat, m_sat); end
      if (snap_valid !== m_sv)    begin errors++; $display("FAIL rnd_sv[%0d]: got %b want %b", i, snap_valid, m_sv); end
      if (snap_count !== W'(m_sc)) begin errors++; $display("FAIL rnd_sc[%0d]: got %0d want %0d", i, snap_count, m_sc); end
    end
    clear = 1'b0; snap_req = 1'b0; snap_ack = 1'b0; rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_saturation();
    test_snapshot();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_edge_monitor.md
# q_edge_monitor

Downstream consumer of the one-flip-flop stage's `q` output. It registers `q`, debounces it over a programmable number of cycles, and emits single-cycle rise and fall pulses. It keeps a saturating transition counter that a host reads through a req/ack snapshot handshake. It runs on the same clock as the stage that drives it, so `q_in` needs no synchronizer.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive differing samples required to accept a level change. Legal range 1..255.
- `CNT_WIDTH`, default 16: width of the transition counter and the snapshot. Legal range 2..32.

Ports:
- `clock0` input, 1: single clock; all state updates on its rising edge.
- `rstn` input, 1: synchronous, active-low reset, sampled on the rising edge of `clock0`.
- `q_in` input, 1: `q` from the flip-flop stage.
- `clear` input, 1: synchronous clear of the counter and the saturation flag.
- `stable_q` output, 1: debounced level.
- `rise_pulse` output, 1: one-cycle pulse on an accepted 0→1 change.
- `fall_pulse` output, 1: one-cycle pulse on an accepted 1→0 change.
- `edge_count` output, `CNT_WIDTH`: accepted transitions, both directions.
- `count_sat` output, 1: sticky; set when `edge_count` reaches all-ones.
- `snap_req` input, 1: host snapshot request.
- `snap_ack` input, 1: host acknowledge.
- `snap_valid` output, 1: snapshot held and valid.
- `snap_count` output, `CNT_WIDTH`: captured `edge_count`.

## Operation
- **Reset.** `rstn`=0 at an edge sets all registers to 0: `q_r`, `run_cnt`, `stable_q`, both pulses, `edge_count`, `count_sat`, `snap_valid`, `snap_count`, FSM=IDLE.
  - Reset wins over every other input and aborts a HOLD in progress.
- **Sample stage.** `q_r <= q_in` every edge.
- **Debounce.** `run_cnt` is 8 bits.
  - If `q_r == stable_q`: `run_cnt <= 0`.
  - Else if `run_cnt == DEBOUNCE_CYCLES-1`: `stable_q <= q_r` and `run_cnt <= 0`.
  - Else: `run_cnt <= run_cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples restarts the count and never changes `stable_q`.
- **Pulses.** Registered, asserted on the same edge that `stable_q` changes:
  - `rise_pulse` when the new value is 1.
  - `fall_pulse` when the new value is 0.
  - Both are low otherwise and never high together.
- **Counter.** On a pulse edge, `edge_count <= edge_count+1` unless it is already all-ones, in which case it holds.
  - `count_sat <= 1` on the edge `edge_count` becomes all-ones; it stays set until `clear` or reset.
- **Clear.** `clear`=1 sets `edge_count` and `count_sat` to 0.
  - If a pulse occurs on the same edge, clear wins and that transition is not counted.
  - `clear` does not touch the debouncer, the pulses or the snapshot.
- **Snapshot FSM**, states IDLE and HOLD:
  - IDLE & `snap_req`=1: `snap_count <= edge_count` (the pre-edge value, excluding any increment on that edge), `snap_valid <= 1`, go to HOLD.
  - HOLD: `snap_count` is frozen and `snap_req` is ignored. On `snap_ack`=1: `snap_valid <= 0`, go to IDLE.
  - `snap_ack` in IDLE is ignored.
  - `snap_req` and `snap_ack` both high in IDLE: capture (ack ignored). Both high in HOLD: release (req ignored).
  - A new capture needs `snap_req` seen in IDLE, i.e. at least one cycle after release.

## Timing
- Let edge k be the first edge at which `q_in` samples a new value, held stable thereafter. Then:
  - `q_r` changes at k.
  - `stable_q` and the pulse take effect at edge k+`DEBOUNCE_CYCLES`, with the pulse high for exactly one cycle.
  - `edge_count` updates at k+`DEBOUNCE_CYCLES`+1.
- `DEBOUNCE_CYCLES`=1: `stable_q` changes at k+1.
- Snapshot: `snap_valid` rises one edge after `snap_req` is sampled in IDLE and falls one edge after `snap_ack` is sampled in HOLD. Minimum HOLD duration is one cycle.
- `q_in` toggling every cycle with `DEBOUNCE_CYCLES`≥2 produces no pulses.

## Test plan
- **Reset/debounce.** After reset, all outputs are 0. Then drive `q_in`=1 from edge 10 with `DEBOUNCE_CYCLES`=4 → `stable_q`=1 and `rise_pulse`=1 at edge 14 only; `edge_count`=1 at edge 15.
- **Glitch rejection.** Drive `q_in`=1 for 3 cycles, then 0, with `DEBOUNCE_CYCLES`=4 → no pulse, `stable_q` stays 0, `edge_count` stays 0.
- **Saturation and clear.** With `CNT_WIDTH`=4, apply 20 accepted transitions → `edge_count`=15, `count_sat`=1. Pulse `clear` for one cycle → both 0. Then `clear` coincident with a pulse → `edge_count` stays 0.
- **Snapshot.** With `edge_count`=7, raise `snap_req` → `snap_valid`=1 next cycle with `snap_count`=7. Apply further transitions → `snap_count` stays 7. Raise `snap_ack` → `snap_valid`=0 next cycle. A second `snap_req` then captures the new count.
- **Simultaneous events.** `snap_req` on the same edge as a pulse that moves `edge_count` 3→4 → `snap_count`=3. `snap_ack` in IDLE → no effect.
- **Reset mid-operation.** Assert `rstn`=0 for one edge while in HOLD with `run_cnt`=2 → `snap_valid`=0, `edge_count`=0, `stable_q`=0 after that edge. Normal operation resumes afterwards.
